// File: rtl/shade_actuator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shade_actuator : steps a tracked shade position toward a latched target level,
//                  one level per STEP_CYCLES clocks, with a brake cycle on reversal.
// Revision 1.0
// ----------------------------------------------------------------------------
module shade_actuator #(
   parameter int unsigned STEP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] wshade,
   input  logic       load,
   output logic       motor_up,
   output logic       motor_down,
   output logic [3:0] level,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      BRAKE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] RELOAD = 8'(STEP_CYCLES - 1);

   state_t     state, state_nx;
   logic [3:0] level_nx, target, target_nx, tgt_eff;
   logic [7:0] count, count_nx;
   logic       suppress;

   always_comb begin
      state_nx  = state;
      level_nx  = level;
      target_nx = target;
      count_nx  = count;
      suppress  = 1'b0;
      tgt_eff   = load ? wshade : target;
      case (state)
         IDLE, DONE: begin
            if (load) begin
               target_nx = wshade;
               if (wshade > level) begin
                  state_nx = UP;
                  count_nx = RELOAD;
               end else if (wshade < level) begin
                  state_nx = DOWN;
                  count_nx = RELOAD;
               end else begin
                  state_nx = DONE;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         UP, DOWN: begin
            // Retarget is judged against the pre-step level.
            if (load) begin
               target_nx = wshade;
               if (wshade == level) begin
                  state_nx = DONE;
                  suppress = 1'b1;
               end else if ((wshade > level) != (state == UP)) begin
                  state_nx = BRAKE;
               end
            end
            if (!suppress) begin
               if (count == 8'd0) begin
                  level_nx = (state == UP) ? level + 4'd1 : level - 4'd1;
                  count_nx = RELOAD;
                  if (state_nx == state && level_nx == target_nx) begin
                     state_nx = DONE;
                  end
               end else begin
                  count_nx = count - 8'd1;
               end
            end
         end
         BRAKE: begin
            target_nx = tgt_eff;
            if (tgt_eff > level) begin
               state_nx = UP;
               count_nx = RELOAD;
            end else if (tgt_eff < level) begin
               state_nx = DOWN;
               count_nx = RELOAD;
            end else begin
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         level      <= 4'd0;
         target     <= 4'd0;
         count      <= 8'd0;
         motor_up   <= 1'b0;
         motor_down <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         level      <= level_nx;
         target     <= target_nx;
         count      <= count_nx;
         motor_up   <= (state_nx == UP);
         motor_down <= (state_nx == DOWN);
         busy       <= (state_nx == UP) || (state_nx == DOWN) || (state_nx == BRAKE);
         done       <= (state_nx == DONE);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shade_actuator.sv
`default_nettype none
// Scoreboard bench for shade_actuator: expected output vectors are queued when
// stimulus is applied and compared one per clock.
module tb_shade_actuator;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [3:0] wshade = 4'd0;
   logic       motor_up, motor_down, busy, done;
   logic [3:0] level;

   shade_actuator #(.STEP_CYCLES(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .wshade     (wshade),
      .load       (load),
      .motor_up   (motor_up),
      .motor_down (motor_down),
      .level      (level),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   string      phase = "reset";

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got {up,dn,busy,done,lvl}=%b required=%b", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] vec(input logic up, input logic dn, input logic bz,
                                      input logic dn_pulse, input logic [3:0] lvl);
      return {up, dn, bz, dn_pulse, lvl};
   endfunction

   // Queue an N-level move: level changes after every S cycles of motor drive.
   task automatic push_move(input int start, input int dir, input int first, input int cnt);
      for (int k = first; k < first + cnt; k++) begin
         logic [3:0] l;
         l = (dir > 0) ? 4'(start + k / S) : 4'(start - k / S);
         exp_q.push_back(vec(dir > 0, dir < 0, 1'b1, 1'b0, l));
      end
   endtask

   task automatic push_done(input logic [3:0] lvl);
      exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b1, lvl));
   endtask

   task automatic push_idle(input logic [3:0] lvl, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, lvl));
   endtask

   task automatic tick();
      logic [7:0] obs;
      @(posedge clk);
      #1;
      obs = {motor_up, motor_down, busy, done, level};
      if (exp_q.size() == 0) check({phase, "_underflow"}, obs, 8'hFF);
      else check(phase, obs, exp_q.pop_front());
   endtask

   task automatic drain();
      while (exp_q.size() > 0) tick();
   endtask

   task automatic do_load(input logic [3:0] w);
      load   = 1'b1;
      wshade = w;
      tick();
      load   = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         push_idle(4'd0, 1);
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      phase = "reset";
      apply_reset(2);

      phase = "up_0_to_15";
      push_move(0, 1, 0, 60);
      push_done(4'd15);
      push_idle(4'd15, 3);
      do_load(4'd15);
      drain();

      phase = "down_15_to_11";
      push_move(15, -1, 0, 16);
      push_done(4'd11);
      push_idle(4'd11, 2);
      do_load(4'd11);
      drain();

      phase = "equal_level";
      push_done(4'd11);
      push_idle(4'd11, 3);
      do_load(4'd11);
      drain();

      phase = "reset2";
      apply_reset(1);
      phase = "brake_reverse";
      push_move(0, 1, 0, 10);
      do_load(4'd8);
      repeat (9) tick();
      exp_q.push_back(vec(1'b0, 1'b0, 1'b1, 1'b0, 4'd2));
      push_move(2, -1, 0, 8);
      push_done(4'd0);
      push_idle(4'd0, 2);
      do_load(4'd0);
      drain();

      phase = "abort_move";
      push_move(0, 1, 0, 21);
      do_load(4'd15);
      repeat (20) tick();
      phase = "abort_reset";
      apply_reset(1);
      push_idle(4'd0, 1);
      tick();
      phase = "after_abort";
      push_move(0, 1, 0, 4);
      push_done(4'd1);
      push_idle(4'd1, 2);
      do_load(4'd1);
      drain();

      phase = "reset3";
      apply_reset(1);
      phase = "same_dir_retarget";
      push_move(0, 1, 0, 5);
      do_load(4'd4);
      repeat (4) tick();
      push_move(0, 1, 5, 19);
      push_done(4'd6);
      push_idle(4'd6, 2);
      do_load(4'd6);
      drain();

      phase = "zero_equal";
      apply_reset(1);
      push_done(4'd0);
      push_idle(4'd0, 2);
      do_load(4'd0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
